// File: rtl/dbus_sram_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbus_sram_responder_pkg : shared data-bus request/response types and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package dbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  function automatic logic is_misaligned(input msize_t size, input logic [1:0] lsb);
    return ((size == MSIZE2) && lsb[0]) || ((size == MSIZE4) && (lsb != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_sram_responder_resp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// resp_pipe : LATENCY-stage valid/data shift pipeline with synchronous clear
// Rev 1.0
// ----------------------------------------------------------------------------
module resp_pipe #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [LATENCY];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Data is qualified by the valid bits, so it needs no clear.
  always_ff @(posedge clk) begin
    r_data[0] <= i_data;
    for (int i = 1; i < LATENCY; i++) begin
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dbus_sram_responder : fixed-latency in-order SRAM responder on the data bus
// Rev 1.0
// ----------------------------------------------------------------------------
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  input  logic       stall,
  output logic       err
);

  localparam int          C_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] C_SPAN = 33'(64'(DEPTH_WORDS) * 64'd4);

  logic [3:0][7:0] r_mem [DEPTH_WORDS];
  logic            r_err;

  logic            w_addr_ok;
  logic            w_hs;
  logic            w_in_range;
  logic            w_misaligned;
  logic            w_ok;
  logic            w_wr;
  logic            w_rd;
  logic [31:0]     w_off;
  logic [C_AW-1:0] w_idx;
  logic [31:0]     w_rdata;
  logic [31:0]     w_pipe_din;
  logic            w_pipe_vout;
  logic [31:0]     w_pipe_dout;
  logic            w_data_ok;

  assign w_addr_ok    = dreq.valid & ~stall & ~reset;
  assign w_hs         = dreq.valid & w_addr_ok;

  // Unsigned compare on the offset also rejects addresses below BASE_ADDR.
  assign w_off        = dreq.addr - BASE_ADDR;
  assign w_idx        = w_off[C_AW+1:2];
  assign w_in_range   = ({1'b0, w_off} < C_SPAN);
  assign w_misaligned = is_misaligned(dreq.size, dreq.addr[1:0]);
  assign w_ok         = w_in_range & ~w_misaligned;
  assign w_wr         = w_hs & w_ok & (|dreq.strobe);
  assign w_rd         = w_hs & w_ok & ~(|dreq.strobe);

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr && dreq.strobe[i]) begin
        r_mem[w_idx][i] <= dreq.data[8*i +: 8];
      end
    end
  end

  assign w_rdata    = r_mem[w_idx];
  assign w_pipe_din = w_rd ? w_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_hs && !w_ok) begin
      r_err <= 1'b1;
    end
  end

  resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (32)
  ) u_resp_pipe (
    .clk     (clk),
    .i_clr   (reset),
    .i_valid (w_hs),
    .i_data  (w_pipe_din),
    .o_valid (w_pipe_vout),
    .o_data  (w_pipe_dout)
  );

  // Gate with reset so outputs are quiet during the first reset cycle too.
  assign w_data_ok = w_pipe_vout & ~reset;

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = w_addr_ok;
    dresp.data_ok = w_data_ok;
    dresp.data    = w_data_ok ? w_pipe_dout : 32'h0;
  end

  assign err = r_err & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dbus_sram_responder : directed scoreboard bench for dbus_sram_responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       err;

  int          cyc = 0;
  int          nasrt = 0;
  int          nfail = 0;
  logic        exp_err = 1'b0;
  exp_t        q[$];
  logic [31:0] mem_m [int];

  dbus_sram_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq),
    .dresp (dresp),
    .stall (stall),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nasrt++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Response monitor: pops the scoreboard on data_ok and checks timing.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("rst_addr_ok", 32'(dresp.addr_ok), 32'h0);
      chk("rst_data_ok", 32'(dresp.data_ok), 32'h0);
      chk("rst_data",    dresp.data, 32'h0);
      chk("rst_err",     32'(err), 32'h0);
    end else if (dresp.data_ok) begin
      if (q.size() == 0) begin
        chk("spurious_data_ok", 32'h1, 32'h0);
      end else begin
        e = q.pop_front();
        chk("resp_data",    dresp.data, e.data);
        chk("resp_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_data_zero", dresp.data, 32'h0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_data_ok", 32'h0, 32'h1);
        void'(q.pop_front());
      end
    end
  end

  // Drive one request; holds valid until handshake and leaves it asserted
  // so consecutive calls are back-to-back.
  task automatic issue(input logic [31:0] a, input msize_t sz, input logic [3:0] st,
                       input logic [31:0] d, output int hs);
    logic [31:0] off;
    logic        ok;
    logic [31:0] w;
    int          idx;
    exp_t        e;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = sz;
    dreq.strobe = st;
    dreq.data   = d;
    hs = -1;
    for (int k = 0; k < 20 && hs < 0; k++) begin
      @(negedge clk);
      if (dresp.addr_ok) begin
        hs  = cyc;
        off = a - BASE;
        ok  = (64'(off) < 64'(DEPTH) * 64'd4) &&
              !((sz == MSIZE2 && a[0]) || (sz == MSIZE4 && a[1:0] != 2'b00));
        idx = int'(off >> 2);
        e.due  = cyc + LAT;
        e.data = (ok && st == 4'h0) ? mem_m[idx] : 32'h0;
        q.push_back(e);
        if (!ok) exp_err = 1'b1;
        if (ok && st != 4'h0) begin
          w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
          mem_m[idx] = w;
        end
      end
      @(posedge clk); #1;
    end
    if (hs < 0) chk("handshake_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    dreq.valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int h0, h1, hfirst, hlast, c0;
    dreq = '0;
    dreq.valid = 1'b1;
    dreq.addr  = 32'h10;
    dreq.strobe = 4'hF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    dreq.valid = 1'b0;
    reset = 1'b0;
    chk("err_after_reset", 32'(err), 32'h0);
    idle(2);

    // Write then read same word on the next cycle.
    issue(32'h10, MSIZE4, 4'hF, 32'hDEADBEEF, h0);
    issue(32'h10, MSIZE4, 4'h0, 32'h0, h1);
    idle(1);
    chk("raw_hs_gap", 32'(h1 - h0), 32'h1);
    idle(4);

    // Byte-lane merge.
    issue(32'h20, MSIZE4, 4'hF, 32'h11223344, h0);
    issue(32'h20, MSIZE1, 4'b0010, 32'h0000AA00, h0);
    issue(32'h20, MSIZE4, 4'h0, 32'h0, h0);
    idle(4);

    // Back-to-back writes then reads over eight words.
    for (int i = 0; i < 8; i++) issue(32'(4*i), MSIZE4, 4'hF, 32'hA0000000 + 32'(i) * 32'h01010101, h0);
    hfirst = 0;
    hlast  = 0;
    for (int i = 0; i < 8; i++) begin
      issue(32'(4*i), MSIZE4, 4'h0, 32'h0, h0);
      if (i == 0) hfirst = h0;
      if (i == 7) hlast = h0;
    end
    idle(1);
    chk("b2b_hs_span", 32'(hlast - hfirst), 32'h7);
    idle(4);

    // Aligned sub-word writes.
    issue(32'h3, MSIZE1, 4'b1000, 32'h77000000, h0);
    issue(32'h6, MSIZE2, 4'b1100, 32'h55660000, h0);
    issue(32'h0, MSIZE4, 4'h0, 32'h0, h0);
    issue(32'h4, MSIZE4, 4'h0, 32'h0, h0);
    idle(4);

    // Stalled write must not land; fields change before stall drops.
    issue(32'h44, MSIZE4, 4'hF, 32'h0BADCAFE, h0);
    idle(3);
    stall       = 1'b1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h44;
    dreq.size   = MSIZE4;
    dreq.strobe = 4'hF;
    dreq.data   = 32'hBAD0BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_addr_ok", 32'(dresp.addr_ok), 32'h0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    c0 = cyc;
    issue(32'h44, MSIZE4, 4'h0, 32'h0, h0);
    idle(1);
    chk("stall_release_hs", 32'(h0), 32'(c0));
    idle(4);

    // Out-of-range and misaligned requests.
    chk("err_before_bad", 32'(err), 32'h0);
    issue(BASE + 32'(DEPTH) * 32'd4, MSIZE4, 4'h0, 32'h0, h0);
    dreq.valid = 1'b0;
    chk("err_after_oor", 32'(err), 32'(exp_err));
    issue(32'h2, MSIZE4, 4'hF, 32'hFFFFFFFF, h0);
    issue(32'h5, MSIZE2, 4'h0, 32'h0, h0);
    issue(32'h0, MSIZE4, 4'h0, 32'h0, h0);
    idle(4);
    chk("err_sticky", 32'(err), 32'h1);

    // Reset with two reads in flight.
    issue(32'h80, MSIZE4, 4'hF, 32'h5A5AA5A5, h0);
    idle(3);
    issue(32'h0, MSIZE4, 4'h0, 32'h0, h0);
    issue(32'h4, MSIZE4, 4'h0, 32'h0, h0);
    dreq.valid = 1'b0;
    reset = 1'b1;
    q.delete();
    exp_err = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    chk("err_cleared", 32'(err), 32'(exp_err));
    idle(6);
    issue(32'h80, MSIZE4, 4'h0, 32'h0, h0);
    idle(6);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
